pll_reset_ctrl: RTL and testbench

Reset sequencer feeding the Gowin PLL clock generator's active-high reset input. It runs on the raw board clock (27 MHz) and sequences the PLL reset from three sources: system reset, a debounced user button, and PLL lock supervision. It holds the PLL in reset for a minimum width and waits for a stable lock, with a timeout. It retries the PLL reset on timeout or lock loss and reports readiness and the retry count to status logic.

---
 rtl/pll_reset_ctrl_if.sv | 26 ++
 rtl/pll_reset_ctrl.sv | 159 +++++++++++++++
 tb/tb_pll_reset_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/pll_reset_ctrl_if.sv
// Board-side signal bundle of the PLL reset sequencer: button and lock in,
// PLL reset, ready flag and retry count out.
interface pll_reset_ctrl_if;
  logic       i_btn_n;
  logic       i_lock;
  logic       o_pll_rst;
  logic       o_ready;
  logic [3:0] o_retry_cnt;

  // master is the sequencer, slave is the board/PLL/status side
  modport master (
    input  i_btn_n,
    input  i_lock,
    output o_pll_rst,
    output o_ready,
    output o_retry_cnt
  );

  modport slave (
    output i_btn_n,
    output i_lock,
    input  o_pll_rst,
    input  o_ready,
    input  o_retry_cnt
  );
endinterface

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: holds the PLL in reset, waits for a stable lock with a
// timeout, retries on timeout or lock loss, and restarts on a debounced button.
module pll_reset_ctrl #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int RST_HOLD_CYCLES = 27,
  parameter int LOCK_TIMEOUT    = 27000,
  parameter int LOCK_STABLE     = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  pll_reset_ctrl_if.master  bus
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HOLD_W = $clog2(RST_HOLD_CYCLES) + 1;
  localparam int WAIT_W = $clog2(LOCK_TIMEOUT) + 1;
  localparam int STAB_W = $clog2(LOCK_STABLE) + 1;

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LOCK_TIMEOUT - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE - 1);

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_WAIT_LOCK,
    ST_RUN
  } state_t;

  // Two-flop synchronizers; the button idles released (1), lock idles low.
  logic btn_meta, btn_s;
  logic lock_meta, lock_s;

  // NOTE: non-blocking assignments make every flop sample the value from
  // before the edge, which is what turns these lines into a register chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      btn_meta  <= 1'b1;
      btn_s     <= 1'b1;
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      btn_meta  <= bus.i_btn_n;
      btn_s     <= btn_meta;
      lock_meta <= bus.i_lock;
      lock_s    <= lock_meta;
    end
  end

  // Debouncer: a level change is accepted after DEBOUNCE_CYCLES consecutive
  // differing samples; only the press (1->0) produces a pulse.
  logic             btn_stable;
  logic             btn_press;
  logic [DEB_W-1:0] deb_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      btn_stable <= 1'b1;
      btn_press  <= 1'b0;
      deb_cnt    <= '0;
    end else begin
      btn_press <= 1'b0;
      if (btn_s == btn_stable) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        btn_stable <= btn_s;
        btn_press  <= ~btn_s;
        deb_cnt    <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  // Sequencer state and per-state counters.
  state_t              state_q, state_d;
  logic                retry_inc;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [STAB_W-1:0]   stab_cnt;
  logic                pll_rst_q;
  logic                ready_q;
  logic [3:0]          retry_q;

  // NOTE: every output of this block gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    retry_inc = 1'b0;
    unique case (state_q)
      ST_HOLD: begin
        // Presses during HOLD are ignored so the reset pulse is never stretched.
        if (hold_cnt == HOLD_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (btn_press) begin
          state_d = ST_HOLD;
        end else if (lock_s && (stab_cnt == STAB_LAST)) begin
          state_d = ST_RUN;
        end else if (wait_cnt == WAIT_LAST) begin
          state_d   = ST_HOLD;
          retry_inc = 1'b1;
        end
      end
      ST_RUN: begin
        // Lock loss outranks the button so a coincident press still counts a retry.
        if (!lock_s) begin
          state_d   = ST_HOLD;
          retry_inc = 1'b1;
        end else if (btn_press) begin
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_HOLD;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_cnt <= '0;
      wait_cnt <= '0;
      stab_cnt <= '0;
    end else if (state_d != state_q) begin
      hold_cnt <= '0;
      wait_cnt <= '0;
      stab_cnt <= '0;
    end else begin
      unique case (state_q)
        ST_HOLD: hold_cnt <= hold_cnt + HOLD_W'(1);
        ST_WAIT_LOCK: begin
          // A lock glitch restarts stability but leaves the timeout running.
          wait_cnt <= wait_cnt + WAIT_W'(1);
          stab_cnt <= lock_s ? stab_cnt + STAB_W'(1) : '0;
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from the next state so they switch on the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_HOLD;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      retry_q   <= '0;
    end else begin
      state_q   <= state_d;
      pll_rst_q <= (state_d == ST_HOLD);
      ready_q   <= (state_d == ST_RUN);
      if (retry_inc && (retry_q != 4'hF)) retry_q <= retry_q + 4'd1;
    end
  end

  assign bus.o_pll_rst   = pll_rst_q;
  assign bus.o_ready     = ready_q;
  assign bus.o_retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Bench for pll_reset_ctrl: a fixed vector table, hand-written corner
// sequences, and randomized stimulus against a time-based reference model.
module tb_pll_reset_ctrl;

  localparam int D = 4;
  localparam int H = 3;
  localparam int T = 10;
  localparam int S = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pll_reset_ctrl_if bus ();

  pll_reset_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .RST_HOLD_CYCLES(H),
    .LOCK_TIMEOUT   (T),
    .LOCK_STABLE    (S)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  logic [5:0] dut_o;
  assign dut_o = {bus.o_pll_rst, bus.o_ready, bus.o_retry_cnt};

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got pll_rst=%b ready=%b retry=%0d, expected pll_rst=%b ready=%b retry=%0d",
               name, $time, act[5], act[4], act[3:0], exp[5], exp[4], exp[3:0]);
    end
  endtask

  // Reference model: inputs reach the logic two edges late, the button is
  // accepted after D differing samples, and each phase is timed by the edge
  // number at which it was entered.
  typedef enum {M_HOLD, M_WAIT, M_RUN} mphase_t;
  mphase_t m_phase;
  int      m_edge, m_entry, m_retry, m_lock_run, m_deb_run;
  bit      m_stable, m_press_pending;
  bit      bq[$];
  bit      lq[$];

  function automatic logic [5:0] model_out();
    return {m_phase == M_HOLD, m_phase == M_RUN, 4'(m_retry)};
  endfunction

  task automatic model_reset();
    m_phase = M_HOLD; m_edge = 0; m_entry = 0; m_retry = 0;
    m_lock_run = 0; m_deb_run = 0; m_stable = 1'b1; m_press_pending = 1'b0;
    bq = {1'b1, 1'b1};
    lq = {1'b0, 1'b0};
  endtask

  task automatic model_enter(input mphase_t p);
    m_phase = p; m_entry = m_edge; m_lock_run = 0;
  endtask

  task automatic model_retry();
    m_retry = (m_retry < 15) ? m_retry + 1 : 15;
  endtask

  task automatic model_step(input bit btn, input bit lock);
    bit b_seen, l_seen, press;
    int age;
    m_edge++;
    b_seen = bq.pop_front(); bq.push_back(btn);
    l_seen = lq.pop_front(); lq.push_back(lock);
    press = m_press_pending;
    m_press_pending = 1'b0;
    if (b_seen == m_stable) m_deb_run = 0;
    else begin
      m_deb_run++;
      if (m_deb_run == D) begin
        m_stable = b_seen; m_deb_run = 0; m_press_pending = !b_seen;
      end
    end
    age = m_edge - m_entry;
    case (m_phase)
      M_HOLD: if (age == H) model_enter(M_WAIT);
      M_WAIT: begin
        m_lock_run = l_seen ? m_lock_run + 1 : 0;
        if (press) model_enter(M_HOLD);
        else if (m_lock_run == S) model_enter(M_RUN);
        else if (age == T) begin model_enter(M_HOLD); model_retry(); end
      end
      default: begin
        if (!l_seen) begin model_enter(M_HOLD); model_retry(); end
        else if (press) model_enter(M_HOLD);
      end
    endcase
  endtask

  // One clock: inputs change 1 time unit after the previous edge, outputs
  // are compared 1 time unit after this edge.
  task automatic cycle(input bit btn, input bit lock, input string name);
    bus.i_btn_n = btn;
    bus.i_lock  = lock;
    @(posedge clk);
    model_step(btn, lock);
    #1 check(name, dut_o, model_out());
  endtask

  // Asserts reset between edges and checks outputs with no clock edge.
  task automatic do_reset(input bit lock0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    bus.i_btn_n = 1'b1;
    bus.i_lock  = lock0;
    model_reset();
    #1 check("async_reset", dut_o, 6'b10_0000);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  typedef struct packed {
    bit         btn;
    bit         lock;
    bit         pll_rst;
    bit         ready;
    logic [3:0] retry;
  } vec_t;

  vec_t tbl[15];

  initial begin
    bit btn, lock;
    int lock_div, btn_div;

    // Power-up with lock high, then lock loss and recovery.
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd1};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd1};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd1};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd1};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd1};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd1};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd1};

    bus.i_btn_n = 1'b1;
    bus.i_lock  = 1'b0;

    do_reset(1'b1);
    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].btn, tbl[i].lock, "table_model");
      check($sformatf("table[%0d]", i), dut_o,
            {tbl[i].pll_rst, tbl[i].ready, tbl[i].retry});
    end

    // Lock never arrives: 3 high / 10 low, retry saturating at 15.
    do_reset(1'b0);
    for (int i = 1; i <= 220; i++) begin
      cycle(1'b1, 1'b0, "timeout_model");
      check($sformatf("timeout[%0d]", i), dut_o,
            {(i % 13) < 3, 1'b0, 4'((i / 13 > 15) ? 15 : i / 13)});
    end

    // Button: 3-cycle glitch is ignored, 6-cycle press resets the PLL.
    do_reset(1'b1);
    repeat (10) cycle(1'b1, 1'b1, "btn_setup");
    for (int j = 1; j <= 11; j++) begin
      cycle(j > 3, 1'b1, "glitch_model");
      check($sformatf("btn_glitch[%0d]", j), dut_o, 6'b01_0000);
    end
    for (int j = 1; j <= 14; j++) begin
      cycle(j > 6, 1'b1, "press_model");
      check($sformatf("btn_press[%0d]", j), dut_o,
            {(j >= 7) && (j <= 9), (j <= 6) || (j >= 12), 4'd0});
    end

    // Button press coincides with the lock timeout: no retry counted.
    do_reset(1'b0);
    for (int i = 1; i <= 16; i++) begin
      cycle(!((i >= 7) && (i <= 14)), 1'b0, "btn_timeout_model");
      if (i == 12) check("btn_timeout_before", dut_o, 6'b00_0000);
      if (i == 13) check("btn_timeout_edge", dut_o, 6'b10_0000);
    end

    // Lock loss coincides with a button press in RUN: retry counted.
    do_reset(1'b1);
    for (int i = 1; i <= 22; i++) begin
      cycle(!((i >= 6) && (i <= 13)), !((i >= 10) && (i <= 12)), "loss_btn_model");
      if (i == 11) check("loss_btn_before", dut_o, 6'b01_0000);
      if (i == 12) check("loss_btn_edge", dut_o, 6'b10_0001);
    end

    // Async reset while waiting for lock after one retry.
    do_reset(1'b0);
    for (int i = 1; i <= 18; i++) cycle(1'b1, 1'b0, "pre_abort_model");
    check("pre_abort_wait", dut_o, 6'b00_0001);
    do_reset(1'b1);

    // Randomized level streams with differing toggle rates per segment.
    for (int seg = 0; seg < 4; seg++) begin
      lock     = 1'($urandom_range(0, 1));
      btn      = 1'b1;
      lock_div = 4 + seg * 6;
      btn_div  = 3 + seg * 4;
      do_reset(lock);
      for (int n = 0; n < 500; n++) begin
        if ($urandom_range(0, lock_div - 1) == 0) lock = ~lock;
        if ($urandom_range(0, btn_div - 1) == 0) btn = ~btn;
        cycle(btn, lock, "random_model");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
